// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin IFU/LSU arbiter onto a single memory port with response timeout
module bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_reqValid,
  input  logic        lsu_wen,
  input  logic [3:0]  lsu_wmask,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_reqValid,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;

  localparam logic       OWN_IFU     = 1'b0;
  localparam logic       OWN_LSU     = 1'b1;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  arb_state_t  r_state;
  arb_state_t  w_next_state;
  logic        r_owner;
  logic        r_last;
  logic [7:0]  r_cnt;
  logic        r_mem_wen;
  logic [3:0]  r_mem_wmask;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic w_busy;
  logic w_resp_ok;
  logic w_timeout;
  logic w_done;
  logic w_grant;
  logic w_grant_lsu;

  always_comb begin
    w_next_state = r_state;
    w_busy       = (r_state == ARB_ISSUE) || (r_state == ARB_WAIT);
    w_resp_ok    = w_busy && mem_respValid;
    // A real response in the timeout cycle wins over the forced error.
    w_timeout    = w_busy && !mem_respValid && (r_cnt == TIMEOUT_CNT);
    w_done       = w_resp_ok || w_timeout;
    w_grant      = (r_state == ARB_IDLE) && (ifu_reqValid || lsu_reqValid);
    w_grant_lsu  = lsu_reqValid && (!ifu_reqValid || (r_last == OWN_IFU));
    case (r_state)
      ARB_IDLE:  if (w_grant) w_next_state = ARB_ISSUE;
      ARB_ISSUE: w_next_state = w_done ? ARB_IDLE : ARB_WAIT;
      ARB_WAIT:  if (w_done) w_next_state = ARB_IDLE;
      default:   w_next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    ifu_respValid = 1'b0;
    ifu_rdata     = 32'h0;
    ifu_err       = 1'b0;
    lsu_respValid = 1'b0;
    lsu_rdata     = 32'h0;
    lsu_err       = 1'b0;
    if (!reset && w_done) begin
      if (r_owner == OWN_IFU) begin
        ifu_respValid = 1'b1;
        ifu_err       = w_timeout;
        ifu_rdata     = w_resp_ok ? mem_rdata : 32'h0;
      end else begin
        lsu_respValid = 1'b1;
        lsu_err       = w_timeout;
        lsu_rdata     = w_resp_ok ? mem_rdata : 32'h0;
      end
    end
  end

  // Outputs are forced low while reset is held, even before the first clock edge.
  assign mem_reqValid = !reset && (r_state == ARB_ISSUE);
  assign mem_wen      = !reset && r_mem_wen;
  assign mem_wmask    = reset ? 4'h0 : r_mem_wmask;
  assign mem_addr     = reset ? 32'h0 : r_mem_addr;
  assign mem_wdata    = reset ? 32'h0 : r_mem_wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_IFU;
      r_last      <= OWN_IFU;
      r_cnt       <= 8'h0;
      r_mem_wen   <= 1'b0;
      r_mem_wmask <= 4'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_owner <= w_grant_lsu ? OWN_LSU : OWN_IFU;
        r_cnt   <= 8'h0;
        if (w_grant_lsu) begin
          r_mem_wen   <= lsu_wen;
          r_mem_wmask <= lsu_wmask;
          r_mem_addr  <= lsu_addr;
          r_mem_wdata <= lsu_wdata;
        end else begin
          r_mem_wen   <= 1'b0;
          r_mem_wmask <= 4'h0;
          r_mem_addr  <= ifu_addr;
          r_mem_wdata <= 32'h0;
        end
      end else if (w_busy) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_done) r_last <= r_owner;
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized self-checking bench for bus_arbiter
module tb_bus_arbiter;
  localparam int TO = 12;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        ifu_err;
  logic        lsu_reqValid;
  logic        lsu_wen;
  logic [3:0]  lsu_wmask;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_reqValid;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_respValid;
  logic [31:0] mem_rdata;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_reqValid(lsu_reqValid), .lsu_wen(lsu_wen), .lsu_wmask(lsu_wmask),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_reqValid(mem_reqValid), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Transaction-level model: busy flag, owner (0 IFU, 1 LSU), cycles since issue.
  bit          m_busy  = 0;
  bit          m_owner = 0;
  bit          m_last  = 0;
  int          m_age   = 0;
  logic        m_wen   = 0;
  logic [3:0]  m_wmask = 0;
  logic [31:0] m_addr  = 0;
  logic [31:0] m_wdata = 0;

  logic        s_ifu_resp, s_ifu_err, s_lsu_resp, s_lsu_err, s_mem_req, s_mem_wen;
  logic [31:0] s_ifu_rdata, s_lsu_rdata, s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_wmask;
  bit          mute = 0;
  int          k;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Check the current cycle against the model, snapshot outputs, advance the model, next cycle.
  task automatic cyc();
    bit          done, err, e_ifu, e_lsu, e_req;
    logic [31:0] e_rd;
    #1;
    done  = !reset && m_busy && (mem_respValid || m_age == TO);
    err   = done && !mem_respValid;
    e_rd  = (done && !err) ? mem_rdata : 32'h0;
    e_ifu = done && !m_owner;
    e_lsu = done && m_owner;
    e_req = !reset && m_busy && (m_age == 0);
    cmp1("ifu_respValid", ifu_respValid, e_ifu);
    cmp ("ifu_rdata", ifu_rdata, e_ifu ? e_rd : 32'h0);
    cmp1("ifu_err", ifu_err, e_ifu && err);
    cmp1("lsu_respValid", lsu_respValid, e_lsu);
    cmp ("lsu_rdata", lsu_rdata, e_lsu ? e_rd : 32'h0);
    cmp1("lsu_err", lsu_err, e_lsu && err);
    cmp1("mem_reqValid", mem_reqValid, e_req);
    cmp1("mem_wen", mem_wen, reset ? 1'b0 : m_wen);
    cmp ("mem_wmask", {28'h0, mem_wmask}, reset ? 32'h0 : {28'h0, m_wmask});
    cmp ("mem_addr", mem_addr, reset ? 32'h0 : m_addr);
    cmp ("mem_wdata", mem_wdata, reset ? 32'h0 : m_wdata);
    s_ifu_resp = ifu_respValid; s_ifu_err = ifu_err; s_ifu_rdata = ifu_rdata;
    s_lsu_resp = lsu_respValid; s_lsu_err = lsu_err; s_lsu_rdata = lsu_rdata;
    s_mem_req = mem_reqValid; s_mem_wen = mem_wen; s_mem_wmask = mem_wmask;
    s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;
    if (reset) begin
      m_busy = 0; m_owner = 0; m_last = 0; m_age = 0;
      m_wen = 0; m_wmask = 0; m_addr = 0; m_wdata = 0;
    end else if (m_busy) begin
      if (done) begin
        m_busy = 0;
        m_last = m_owner;
      end else begin
        m_age++;
      end
    end else if (ifu_reqValid || lsu_reqValid) begin
      // LSU wins unless both ask and LSU was served last.
      m_owner = lsu_reqValid && !(ifu_reqValid && m_last);
      m_busy  = 1;
      m_age   = 0;
      if (m_owner) begin
        m_wen = lsu_wen; m_wmask = lsu_wmask; m_addr = lsu_addr; m_wdata = lsu_wdata;
      end else begin
        m_wen = 0; m_wmask = 0; m_addr = ifu_addr; m_wdata = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1; ifu_reqValid = 0; ifu_addr = 0;
    lsu_reqValid = 0; lsu_wen = 0; lsu_wmask = 0; lsu_addr = 0; lsu_wdata = 0;
    mem_respValid = 0; mem_rdata = 0;
    cyc();
    cyc();
    cmp1("reset_mem_req", s_mem_req, 1'b0);
    cmp ("reset_mem_addr", s_mem_addr, 32'h0);
    reset = 0;

    // IFU fetch, memory answers two cycles after issue
    ifu_reqValid = 1; ifu_addr = 32'h8000_0000;
    cyc();
    cmp1("t1_idle_no_req", s_mem_req, 1'b0);
    cyc();
    cmp1("t1_issue", s_mem_req, 1'b1);
    cmp ("t1_addr", s_mem_addr, 32'h8000_0000);
    cmp1("t1_wen", s_mem_wen, 1'b0);
    cyc();
    cmp1("t1_single_req", s_mem_req, 1'b0);
    mem_respValid = 1; mem_rdata = 32'h0000_0413;
    cyc();
    cmp1("t1_resp", s_ifu_resp, 1'b1);
    cmp ("t1_rdata", s_ifu_rdata, 32'h0000_0413);
    cmp1("t1_err", s_ifu_err, 1'b0);
    mem_respValid = 0; ifu_reqValid = 0;
    cyc();

    // Simultaneous requests after reset: LSU store first, then IFU
    reset = 1;
    cyc();
    reset = 0;
    ifu_reqValid = 1; ifu_addr = 32'h8000_0100;
    lsu_reqValid = 1; lsu_wen = 1; lsu_wmask = 4'hF; lsu_addr = 32'h8000_0010; lsu_wdata = 32'hDEAD_BEEF;
    cyc();
    cyc();
    cmp1("t2_lsu_issue", s_mem_req, 1'b1);
    cmp1("t2_lsu_wen", s_mem_wen, 1'b1);
    cmp ("t2_lsu_addr", s_mem_addr, 32'h8000_0010);
    cmp ("t2_lsu_wdata", s_mem_wdata, 32'hDEAD_BEEF);
    cmp ("t2_lsu_wmask", {28'h0, s_mem_wmask}, 32'hF);
    mem_respValid = 1; mem_rdata = 32'h1234_5678;
    cyc();
    cmp1("t2_lsu_resp", s_lsu_resp, 1'b1);
    cmp1("t2_ifu_quiet", s_ifu_resp, 1'b0);
    lsu_reqValid = 0; mem_respValid = 0;
    cyc();
    cmp1("t2_idle_gap", s_mem_req, 1'b0);
    mem_respValid = 1; mem_rdata = 32'hCAFE_0001;
    cyc();
    cmp1("t2_ifu_issue", s_mem_req, 1'b1);
    cmp ("t2_ifu_addr", s_mem_addr, 32'h8000_0100);
    cmp1("t2_ifu_wen", s_mem_wen, 1'b0);
    cmp ("t2_ifu_wdata", s_mem_wdata, 32'h0);
    cmp1("t2_same_cycle_resp", s_ifu_resp, 1'b1);
    cmp ("t2_same_cycle_rdata", s_ifu_rdata, 32'hCAFE_0001);
    mem_respValid = 0;
    cyc();
    cmp1("t2_back_to_idle", s_mem_req, 1'b0);
    cyc();
    cmp1("t2_reissue", s_mem_req, 1'b1);
    ifu_reqValid = 0; mem_respValid = 1;
    cyc();
    mem_respValid = 0;
    cyc();

    // Memory never answers: error after TO counted cycles, late response ignored
    ifu_reqValid = 1; ifu_addr = 32'h8000_0200;
    cyc();
    k = -1;
    for (int i = 0; i <= TO + 4; i++) begin
      cyc();
      if (s_ifu_resp) begin
        k = i;
        break;
      end
    end
    cmp ("t3_timeout_latency", 32'(k), 32'(TO));
    cmp1("t3_err", s_ifu_err, 1'b1);
    cmp ("t3_rdata", s_ifu_rdata, 32'h0);
    ifu_reqValid = 0; mem_respValid = 1; mem_rdata = 32'h5555_AAAA;
    cyc();
    cmp1("t3_late_ignored", s_ifu_resp, 1'b0);
    mem_respValid = 0;
    cyc();

    // Reset during wait aborts silently; next request served normally
    ifu_reqValid = 1; ifu_addr = 32'h8000_0300;
    cyc();
    cyc();
    cyc();
    reset = 1;
    cyc();
    cmp1("t4_reset_no_resp", s_ifu_resp, 1'b0);
    cmp1("t4_reset_no_req", s_mem_req, 1'b0);
    reset = 0; ifu_reqValid = 0; mem_respValid = 1; mem_rdata = 32'h1;
    cyc();
    cmp1("t4_stale_ignored", s_ifu_resp, 1'b0);
    mem_respValid = 0; ifu_reqValid = 1; ifu_addr = 32'h8000_0400;
    cyc();
    cyc();
    cmp ("t4_new_addr", s_mem_addr, 32'h8000_0400);
    mem_respValid = 1; mem_rdata = 32'h0BAD_F00D;
    cyc();
    cmp ("t4_new_rdata", s_ifu_rdata, 32'h0BAD_F00D);
    ifu_reqValid = 0; mem_respValid = 0;
    cyc();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (s_ifu_resp) begin
        ifu_reqValid = $urandom_range(0, 1) == 1;
        ifu_addr = $urandom;
      end else if (ifu_reqValid && m_busy && !m_owner) begin
        ifu_addr = $urandom;
      end else if (ifu_reqValid) begin
        if ($urandom_range(0, 9) == 0) ifu_reqValid = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        ifu_reqValid = 1; ifu_addr = $urandom;
      end
      if (s_lsu_resp || (lsu_reqValid && m_busy && m_owner)) begin
        if (s_lsu_resp) lsu_reqValid = $urandom_range(0, 1) == 1;
        lsu_addr = $urandom; lsu_wdata = $urandom;
        lsu_wen = $urandom_range(0, 1) == 1; lsu_wmask = 4'($urandom);
      end else if (lsu_reqValid) begin
        if ($urandom_range(0, 9) == 0) lsu_reqValid = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        lsu_reqValid = 1; lsu_addr = $urandom; lsu_wdata = $urandom;
        lsu_wen = $urandom_range(0, 1) == 1; lsu_wmask = 4'($urandom);
      end
      mem_rdata = $urandom;
      if (m_busy) begin
        if (m_age == 0) mute = ($urandom_range(0, 5) == 0);
        mem_respValid = !mute && ($urandom_range(0, 2) == 0);
      end else begin
        mem_respValid = ($urandom_range(0, 7) == 0);
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning: cycles waited in ARB_WAIT before an error response is forced.
REQ-002 SHALL have ports `clock`, in, 1, system clock; `reset`, in, 1, synchronous active-high reset.
REQ-003 SHALL have ports `ifu_reqValid`, in, 1, fetch request (level); `ifu_addr`, in, 32, fetch address.
REQ-004 SHALL have ports `ifu_respValid`, out, 1, fetch done pulse; `ifu_rdata`, out, 32, fetch data; `ifu_err`, out, 1, fetch timed out.
REQ-005 SHALL have ports `lsu_reqValid`, in, 1, LSU request (level); `lsu_wen`, in, 1, write; `lsu_wmask`, in, 4, byte enables; `lsu_addr`, in, 32, address; `lsu_wdata`, in, 32, store data.
REQ-006 SHALL have ports `lsu_respValid`, out, 1, LSU done pulse; `lsu_rdata`, out, 32, load data; `lsu_err`, out, 1, LSU timed out.
REQ-007 SHALL have ports `mem_reqValid`, out, 1, request pulse; `mem_wen`, out, 1; `mem_wmask`, out, 4; `mem_addr`, out, 32; `mem_wdata`, out, 32.
REQ-008 SHALL have ports `mem_respValid`, in, 1, memory done; `mem_rdata`, in, 32, memory read data.

Function
REQ-009 SHALL implement FSM states ARB_IDLE, ARB_ISSUE, ARB_WAIT, plus registers owner (IFU/LSU) and last (last-served requester).
REQ-010 SHALL treat each requester's reqValid as a level held until its respValid; deassertion before grant withdraws the request.
REQ-011 In ARB_IDLE with exactly one reqValid high, SHALL grant that requester and go to ARB_ISSUE next cycle.
REQ-012 In ARB_IDLE with both reqValid high, SHALL grant the requester not equal to last (round-robin).
REQ-013 On grant, SHALL latch the winner's addr, wen, wmask, wdata into the mem_* registers; for an IFU grant: mem_wen=0, mem_wmask=0, mem_wdata=0.
REQ-014 After grant, SHALL ignore all requester inputs until that transaction responds.
REQ-015 In ARB_ISSUE, SHALL drive mem_reqValid=1 for exactly that one cycle, then go to ARB_WAIT; mem_reqValid=0 in all other states.
REQ-016 SHALL accept mem_respValid in ARB_ISSUE or ARB_WAIT and ignore it in ARB_IDLE, including late responses after a timeout.
REQ-017 On accepted mem_respValid, SHALL pulse the owner's respValid combinationally the same cycle, with rdata=mem_rdata and err=0, set last=owner, and go to ARB_IDLE.
REQ-018 Resulting minimum latency: request high in cycle N -> mem_reqValid in N+1 -> owner respValid no earlier than N+1.
REQ-019 SHALL count cycles in ARB_ISSUE/ARB_WAIT with an 8-bit counter cleared on grant.
REQ-020 If the counter reaches TIMEOUT without mem_respValid, SHALL pulse the owner's respValid with err=1 and rdata=0, set last=owner, and go to ARB_IDLE.
REQ-021 If mem_respValid arrives in the same cycle the counter reaches TIMEOUT, SHALL give the response priority (err=0).
REQ-022 The non-owner's respValid, rdata and err SHALL be 0; the owner's rdata and err SHALL be 0 whenever its respValid is 0.
REQ-023 SHALL never issue a new mem request while a transaction is outstanding (at most one in flight).
REQ-024 A new grant SHALL occur no earlier than the cycle after a response; each state transition costs exactly one cycle.

Reset
REQ-025 While reset is high at a clock edge, SHALL enter ARB_IDLE with last=IFU, owner=IFU, counter=0, and all mem_* registers 0.
REQ-026 While in reset, all outputs SHALL be 0.
REQ-027 Reset mid-transaction SHALL abort it with no respValid to either requester; the outstanding memory response is discarded per REQ-016.

Verification
REQ-028 IFU only, addr 0x8000_0000; mem responds 2 cycles after issue with 0x0000_0413 -> single mem_reqValid (wen=0) and ifu_respValid with ifu_rdata 0x0000_0413, err=0.
REQ-029 IFU and LSU raise in the same cycle right after reset -> LSU granted first; IFU granted the cycle after lsu_respValid.
REQ-030 LSU store: addr 0x8000_0010, wdata 0xDEAD_BEEF, wmask 0xF, held while IFU also requests -> mem sees exactly those values with wen=1, then an IFU read follows.
REQ-031 Memory never responds -> owner respValid with err=1 and rdata=0 exactly TIMEOUT counted cycles after grant; a later mem_respValid is ignored.
REQ-032 mem_respValid on the same cycle as mem_reqValid -> owner respValid that cycle; state is ARB_IDLE next cycle.
REQ-033 Reset asserted during ARB_WAIT, then mem_respValid -> no respValid pulses; a new IFU request is served normally.
